id_hazard_ctrl: RTL and testbench
=================================

# id_hazard_ctrl

Decode-stage controller for the 5-stage RV32I pipeline. Owns the IF/ID pipeline register that feeds the immediate generator and register file, and sequences it. Detects load-use hazards, injects a bubble into ID/EX, and flushes on taken branches/jumps resolved in EX. Honours a whole-pipeline freeze from the data-memory interface.

## Interface
- `XLEN`, 32, PC/instruction width
- `CNT_W`, 16, width of performance counters (see Configuration)

- `clk`  in  1  single clock; all state on rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `if_instr`  in  32  instruction fetched this cycle
- `if_pc`  in  XLEN  PC of `if_instr`
- `if_valid`  in  1  fetch result valid
- `ex_mem_read`  in  1  instruction in EX is a load
- `ex_rd`  in  5  destination register of instruction in EX
- `ex_redirect`  in  1  taken branch/JAL/JALR resolved in EX this cycle
- `mem_stall`  in  1  data memory busy; freeze entire pipeline
- `pc_write`  out  1  IF may update PC / fetch next
- `id_instr`  out  32  IF/ID register: instruction to decode/ImmGen
- `id_pc`  out  XLEN  IF/ID register: PC
- `id_valid`  out  1  IF/ID register: valid
- `id_bubble`  out  1  load zero controls into ID/EX this cycle
- `stall_cnt`  out  CNT_W  load-use stall cycles (macro only)
- `flush_cnt`  out  CNT_W  redirect flushes (macro only)

## Operation
- Register usage decoded from `id_instr[6:0]`: rs1+rs2 for 0110011, 0100011, 1100011; rs1 only for 0010011, 0000011, 1100111; none for 0110111, 0010111, 1101111 and all other opcodes.
- `hazard` = `id_valid` & `ex_mem_read` & `ex_rd`≠0 & ((uses_rs1 & rs1==`ex_rd`) | (uses_rs2 & rs2==`ex_rd`)).
- FSM states: RUN, STALL.
- Priority per cycle: `mem_stall` > `ex_redirect` > `hazard`.
- `mem_stall`=1: `pc_write`=0, `id_bubble`=0, IF/ID holds, state holds.
- `ex_redirect`=1 (no `mem_stall`): `pc_write`=1, `id_bubble`=1; next edge IF/ID ← NOP (`id_instr`=0x00000013, `id_valid`=0, `id_pc` unchanged); state → RUN.
- RUN & `hazard`: `pc_write`=0, `id_bubble`=1, IF/ID holds; → STALL.
- STALL: `pc_write`=1, `id_bubble`=0, IF/ID loads `if_*`; → RUN. Hazard not re-evaluated in STALL (one stall cycle exactly; MEM→EX forwarding covers the rest).
- RUN, no event: `pc_write`=1, `id_bubble`=0, IF/ID ← {`if_instr`, `if_pc`, `if_valid`}; when `if_valid`=0, `id_instr` loads 0x00000013.

## Timing
- Reset (async assert, sync-safe deassert handled upstream): state=RUN, `id_instr`=0x00000013, `id_pc`=0, `id_valid`=0, counters 0; `pc_write`=1, `id_bubble`=0 during reset.
- `pc_write`, `id_bubble` combinational from state, IF/ID contents and EX/mem inputs; same-cycle.
- IF/ID update latency: 1 cycle (fetch in cycle t visible in ID at t+1).
- Load-use penalty: exactly 1 cycle. Redirect penalty: 2 instructions squashed (ID via bubble, IF via flush).
- Redirect during STALL: redirect wins; STALL abandoned, → RUN.
- `mem_stall` during STALL: state stays STALL until `mem_stall` drops.
- Reset mid-stall: returns to RUN immediately; no stall owed after release.

## Configuration
- `HAZARD_PERF_CNT_EN` defined: `stall_cnt` increments on every cycle with RUN & `hazard` & !`mem_stall` & !`ex_redirect`; `flush_cnt` increments on every `ex_redirect` & !`mem_stall` cycle; both saturate at all-ones.
- Not defined: counters not instantiated; `stall_cnt`, `flush_cnt` tied to 0.

## Test plan
- Reset: `rst_n`=0 mid-run with `id_valid`=1 → `id_instr`=0x00000013, `id_valid`=0, `id_pc`=0 immediately, `pc_write`=1.
- Load-use: ID=`add x3,x1,x2` (0x002081B3), `ex_mem_read`=1, `ex_rd`=1 → `pc_write`=0, `id_bubble`=1 one cycle, ID holds 0x002081B3, next cycle `pc_write`=1, `stall_cnt`=1.
- No false hazard: ID=`lui x1,0x12345` (0x123450B7), `ex_mem_read`=1, `ex_rd`=1 → no stall; ID=`addi x1,x0,2` with `ex_rd`=0 → no stall.
- Redirect: ID=`sw x3,16(x2)` (0x00312823), `ex_redirect`=1 → `id_bubble`=1, next edge `id_instr`=0x00000013, `id_valid`=0, `flush_cnt`=1.
- Priority: hazard and `ex_redirect` same cycle → flush only, no stall; `mem_stall`=1 for 3 cycles during STALL → `pc_write`=0 for 3 cycles, IF/ID frozen, then STALL exit.
- Stream: 8 back-to-back valid fetches, no events → ID sequence equals IF sequence delayed 1 cycle, `pc_write` constant 1.

Source files
------------

// File: rtl/id_hazard_ctrl_if.sv
// Fetch/EX/memory inputs and IF/ID outputs of the decode-stage hazard controller.
// The pipeline side drives through master; the controller itself uses slave.
interface id_hazard_ctrl_if #(
   parameter int XLEN = 32
);
   logic [31:0]     if_instr;
   logic [XLEN-1:0] if_pc;
   logic            if_valid;
   logic            ex_mem_read;
   logic [4:0]      ex_rd;
   logic            ex_redirect;
   logic            mem_stall;
   logic            pc_write;
   logic [31:0]     id_instr;
   logic [XLEN-1:0] id_pc;
   logic            id_valid;
   logic            id_bubble;

   modport master (
      output if_instr, if_pc, if_valid, ex_mem_read, ex_rd, ex_redirect, mem_stall,
      input  pc_write, id_instr, id_pc, id_valid, id_bubble
   );

   modport slave (
      input  if_instr, if_pc, if_valid, ex_mem_read, ex_rd, ex_redirect, mem_stall,
      output pc_write, id_instr, id_pc, id_valid, id_bubble
   );
endinterface

// File: rtl/id_hazard_ctrl.sv
// Decode-stage IF/ID register owner: load-use stall, redirect flush, memory freeze.
// Optional saturating perf counters are built when HAZARD_PERF_CNT_EN is defined.
module id_hazard_ctrl #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   id_hazard_ctrl_if.slave  bus,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);
   localparam logic [31:0] NOP      = 32'h0000_0013;
   localparam logic [0:0]  RUN      = 1'b0;
   localparam logic [0:0]  STALL    = 1'b1;

   localparam logic [6:0]  OP_R     = 7'b0110011;
   localparam logic [6:0]  OP_STORE = 7'b0100011;
   localparam logic [6:0]  OP_BR    = 7'b1100011;
   localparam logic [6:0]  OP_IMM   = 7'b0010011;
   localparam logic [6:0]  OP_LOAD  = 7'b0000011;
   localparam logic [6:0]  OP_JALR  = 7'b1100111;

   logic [0:0]      state;
   logic [0:0]      state_next;
   logic [31:0]     id_instr_q;
   logic [XLEN-1:0] id_pc_q;
   logic            id_valid_q;

   logic [6:0]      opcode;
   logic [4:0]      rs1;
   logic [4:0]      rs2;
   logic            uses_rs1;
   logic            uses_rs2;
   logic            hazard;

   logic            pc_write;
   logic            id_bubble;
   logic            take_fetch;
   logic            squash;
   logic            stall_start;

   assign opcode = id_instr_q[6:0];
   assign rs1    = id_instr_q[19:15];
   assign rs2    = id_instr_q[24:20];

   always_comb begin
      uses_rs1 = 1'b0;
      uses_rs2 = 1'b0;
      case (opcode)
         OP_R, OP_STORE, OP_BR: begin
            uses_rs1 = 1'b1;
            uses_rs2 = 1'b1;
         end
         OP_IMM, OP_LOAD, OP_JALR: uses_rs1 = 1'b1;
         default: ;
      endcase
   end

   assign hazard = id_valid_q && bus.ex_mem_read && (bus.ex_rd != 5'd0) &&
                   ((uses_rs1 && (rs1 == bus.ex_rd)) || (uses_rs2 && (rs2 == bus.ex_rd)));

   // Freeze beats redirect beats load-use; STALL lasts one cycle and never re-checks the hazard.
   always_comb begin
      pc_write    = 1'b1;
      id_bubble   = 1'b0;
      take_fetch  = 1'b0;
      squash      = 1'b0;
      stall_start = 1'b0;
      state_next  = state;
      if (bus.mem_stall) begin
         pc_write = 1'b0;
      end else if (bus.ex_redirect) begin
         id_bubble  = 1'b1;
         squash     = 1'b1;
         state_next = RUN;
      end else if ((state == RUN) && hazard) begin
         pc_write    = 1'b0;
         id_bubble   = 1'b1;
         stall_start = 1'b1;
         state_next  = STALL;
      end else begin
         take_fetch = 1'b1;
         state_next = RUN;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= RUN;
         id_instr_q <= NOP;
         id_pc_q    <= '0;
         id_valid_q <= 1'b0;
      end else begin
         state <= state_next;
         if (squash) begin
            id_instr_q <= NOP;
            id_valid_q <= 1'b0;
         end else if (take_fetch) begin
            id_instr_q <= bus.if_valid ? bus.if_instr : NOP;
            id_pc_q    <= bus.if_pc;
            id_valid_q <= bus.if_valid;
         end
      end
   end

   assign bus.pc_write  = pc_write;
   assign bus.id_bubble = id_bubble;
   assign bus.id_instr  = id_instr_q;
   assign bus.id_pc     = id_pc_q;
   assign bus.id_valid  = id_valid_q;

`ifdef HAZARD_PERF_CNT_EN
   logic [CNT_W-1:0] stall_q;
   logic [CNT_W-1:0] flush_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_q <= '0;
         flush_q <= '0;
      end else begin
         if (stall_start && (stall_q != '1)) stall_q <= stall_q + 1'b1;
         if (squash && (flush_q != '1))      flush_q <= flush_q + 1'b1;
      end
   end

   assign stall_cnt = stall_q;
   assign flush_cnt = flush_q;
`else
   assign stall_cnt = '0;
   assign flush_cnt = '0;
`endif
endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Directed scoreboard bench for id_hazard_ctrl: expectations queued with each stimulus,
// drained and compared once the DUT outputs settle.
module tb_id_hazard_ctrl;
   localparam int XLEN  = 32;
   localparam int CNT_W = 16;
   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef enum int {K_PCW, K_BUB, K_INSTR, K_PC, K_VALID, K_SCNT, K_FCNT} kind_e;
   typedef struct {
      kind_e       kind;
      string       tag;
      logic [31:0] exp;
   } exp_t;

   logic             clk;
   logic             rst_n;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;
   exp_t             sbq[$];
   int               total;
   int               bad;

   id_hazard_ctrl_if #(.XLEN(XLEN)) bus ();

   id_hazard_ctrl #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus),
      .stall_cnt (stall_cnt),
      .flush_cnt (flush_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] cexp(int v);
`ifdef HAZARD_PERF_CNT_EN
      return 32'(v);
`else
      return (v == -1) ? 32'd1 : 32'd0;
`endif
   endfunction

   function automatic logic [31:0] observe(kind_e k);
      case (k)
         K_PCW:   return {31'd0, bus.pc_write};
         K_BUB:   return {31'd0, bus.id_bubble};
         K_INSTR: return bus.id_instr;
         K_PC:    return bus.id_pc;
         K_VALID: return {31'd0, bus.id_valid};
         K_SCNT:  return 32'(stall_cnt);
         default: return 32'(flush_cnt);
      endcase
   endfunction

   task automatic pushExp(kind_e k, string tag, logic [31:0] v);
      exp_t e;
      e.kind = k;
      e.tag  = tag;
      e.exp  = v;
      sbq.push_back(e);
   endtask

   task automatic checkOutput();
      exp_t        e;
      logic [31:0] obs;
      while (sbq.size() > 0) begin
         e   = sbq.pop_front();
         obs = observe(e.kind);
         total++;
         assert (obs === e.exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
         end
      end
   endtask

   task automatic applyStimulus(logic [31:0] instr, logic [31:0] pc, logic valid,
                                logic mr, logic [4:0] rd, logic redir, logic ms);
      bus.if_instr    = instr;
      bus.if_pc       = pc;
      bus.if_valid    = valid;
      bus.ex_mem_read = mr;
      bus.ex_rd       = rd;
      bus.ex_redirect = redir;
      bus.mem_stall   = ms;
   endtask

   // Inputs already applied at a falling edge: check same-cycle controls, clock, check IF/ID.
   task automatic step(string tag, logic pcw, logic bub,
                       logic [31:0] instr, logic [31:0] pc, logic valid);
      pushExp(K_PCW, {tag, ".pc_write"}, {31'd0, pcw});
      pushExp(K_BUB, {tag, ".id_bubble"}, {31'd0, bub});
      #1 checkOutput();
      @(posedge clk);
      #1;
      pushExp(K_INSTR, {tag, ".id_instr"}, instr);
      pushExp(K_PC, {tag, ".id_pc"}, pc);
      pushExp(K_VALID, {tag, ".id_valid"}, {31'd0, valid});
      checkOutput();
      @(negedge clk);
   endtask

   task automatic checkCnt(string tag, int s, int f);
      pushExp(K_SCNT, {tag, ".stall_cnt"}, cexp(s));
      pushExp(K_FCNT, {tag, ".flush_cnt"}, cexp(f));
      checkOutput();
   endtask

   task automatic checkReset(string tag);
      pushExp(K_INSTR, {tag, ".id_instr"}, NOP);
      pushExp(K_VALID, {tag, ".id_valid"}, 32'd0);
      pushExp(K_PC, {tag, ".id_pc"}, 32'd0);
      pushExp(K_PCW, {tag, ".pc_write"}, 32'd1);
      pushExp(K_BUB, {tag, ".id_bubble"}, 32'd0);
      checkOutput();
      checkCnt(tag, 0, 0);
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst_n = 1'b0;
      applyStimulus(32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
      #12 checkReset("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // Load-use on rs1 of add x3,x1,x2
      applyStimulus(32'h002081B3, 32'h100, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
      step("fill_add", 1'b1, 1'b0, 32'h002081B3, 32'h100, 1'b1);
      applyStimulus(32'h00400093, 32'h104, 1'b1, 1'b1, 5'd1, 1'b0, 1'b0);
      step("loaduse", 1'b0, 1'b1, 32'h002081B3, 32'h100, 1'b1);
      checkCnt("loaduse", 1, 0);
      step("stall_exit", 1'b1, 1'b0, 32'h00400093, 32'h104, 1'b1);
      checkCnt("stall_exit", 1, 0);

      // addi x1,x0,4 with ex_rd=0: x0 never hazards
      applyStimulus(32'h123450B7, 32'h108, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
      step("rd_x0", 1'b1, 1'b0, 32'h123450B7, 32'h108, 1'b1);
      // lui has rs1 field = 8 but reads no registers
      applyStimulus(32'h00312823, 32'h10C, 1'b1, 1'b1, 5'd8, 1'b0, 1'b0);
      step("lui_nohaz", 1'b1, 1'b0, 32'h00312823, 32'h10C, 1'b1);

      // Redirect squashes sw in ID; id_pc keeps its value
      applyStimulus(32'h00A00113, 32'h110, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0);
      step("redirect", 1'b1, 1'b1, NOP, 32'h10C, 1'b0);
      checkCnt("redirect", 1, 1);

      // Hazard on rs2 together with redirect: flush only
      applyStimulus(32'h002081B3, 32'h200, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
      step("fill_add2", 1'b1, 1'b0, 32'h002081B3, 32'h200, 1'b1);
      applyStimulus(32'h00000033, 32'h204, 1'b1, 1'b1, 5'd2, 1'b1, 1'b0);
      step("haz_redir", 1'b1, 1'b1, NOP, 32'h200, 1'b0);
      checkCnt("haz_redir", 1, 2);

      // Memory freeze for three cycles in the middle of STALL
      applyStimulus(32'h002081B3, 32'h300, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
      step("fill_add3", 1'b1, 1'b0, 32'h002081B3, 32'h300, 1'b1);
      applyStimulus(32'h0041A233, 32'h304, 1'b1, 1'b1, 5'd2, 1'b0, 1'b0);
      step("haz_rs2", 1'b0, 1'b1, 32'h002081B3, 32'h300, 1'b1);
      bus.mem_stall = 1'b1;
      for (int i = 0; i < 3; i++)
         step($sformatf("freeze%0d", i), 1'b0, 1'b0, 32'h002081B3, 32'h300, 1'b1);
      bus.mem_stall = 1'b0;
      step("freeze_exit", 1'b1, 1'b0, 32'h0041A233, 32'h304, 1'b1);
      checkCnt("freeze_exit", 2, 2);

      // Redirect arriving during STALL abandons the stall
      applyStimulus(32'h00000013, 32'h308, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0);
      step("haz_rs1", 1'b0, 1'b1, 32'h0041A233, 32'h304, 1'b1);
      bus.ex_redirect = 1'b1;
      step("stall_redir", 1'b1, 1'b1, NOP, 32'h304, 1'b0);
      checkCnt("stall_redir", 3, 3);

      // Invalid fetch loads a NOP but still captures the PC
      applyStimulus(32'hDEADBEEF, 32'h400, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
      step("if_invalid", 1'b1, 1'b0, NOP, 32'h400, 1'b0);

      for (int i = 0; i < 8; i++) begin
         applyStimulus(32'h10000000 + 32'(i), 32'h500 + 32'(4 * i), 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
         step($sformatf("stream%0d", i), 1'b1, 1'b0, 32'h10000000 + 32'(i),
              32'h500 + 32'(4 * i), 1'b1);
      end

      // Asynchronous reset while in STALL
      applyStimulus(32'h002081B3, 32'h600, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
      step("fill_add4", 1'b1, 1'b0, 32'h002081B3, 32'h600, 1'b1);
      applyStimulus(32'h00000013, 32'h604, 1'b1, 1'b1, 5'd1, 1'b0, 1'b0);
      step("haz_pre_rst", 1'b0, 1'b1, 32'h002081B3, 32'h600, 1'b1);
      #2 rst_n = 1'b0;
      #1 checkReset("rst_stall");
      @(negedge clk);
      rst_n = 1'b1;
      applyStimulus(32'h00C00293, 32'h700, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
      step("post_rst", 1'b1, 1'b0, 32'h00C00293, 32'h700, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
